// File: rtl/word_packer.sv
// word_packer: packs 32-bit words into 128-bit beats behind a 2-entry output FIFO.
// Optional per-byte even parity on the output beat is enabled by WORD_PACKER_PARITY_EN.
module word_packer #(
  parameter int IN_W  = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_W*WORDS-1:0]     out_data,
  output logic [WORDS-1:0]          out_keep,
  output logic                      out_last
`ifdef WORD_PACKER_PARITY_EN
  ,
  output logic [IN_W*WORDS/8-1:0]   out_parity
`endif
);

  localparam int OUT_W = IN_W * WORDS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } state_e;

`ifdef WORD_PACKER_PARITY_EN
  localparam int PAR_W = OUT_W / 8;

  function automatic logic [PAR_W-1:0] byte_parity(input logic [OUT_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int k = 0; k < PAR_W; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction
`endif

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     asm_q, asm_d;
  logic [WORDS-1:0]     keep_q, keep_d;

  logic [OUT_W-1:0]     mem_data_q [DEPTH];
  logic [WORDS-1:0]     mem_keep_q [DEPTH];
  logic                 mem_last_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic [WORDS-1:0]     out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;

  logic                 in_fire_s;
  logic                 close_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 fwd_s;
  logic [OUT_W-1:0]     beat_data_s;
  logic [WORDS-1:0]     beat_keep_s;

`ifdef WORD_PACKER_PARITY_EN
  logic [PAR_W-1:0]     mem_par_q [DEPTH];
  logic [PAR_W-1:0]     beat_par_s;
  logic [PAR_W-1:0]     out_par_q, out_par_d;
`endif

  assign in_fire_s = in_valid && in_ready_q;

  // Word-index state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL0;
    end else begin
      state_q <= state_d;
    end
  end

  // Word-index next state: advance per accepted word, in_last returns to FILL0
  always_comb begin
    state_d = state_q;
    if (in_fire_s) begin
      if (in_last) begin
        state_d = FILL0;
      end else begin
        case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = FILL2;
          FILL2:   state_d = FILL3;
          FILL3:   state_d = FILL0;
          default: state_d = FILL0;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: beat with the incoming word merged at the current index
  always_comb begin
    beat_data_s = asm_q;
    beat_keep_s = keep_q;
    for (int i = 0; i < WORDS; i++) begin
      if (int'(state_q) == i) begin
        beat_data_s[i*IN_W +: IN_W] = in_data;
        beat_keep_s[i]              = 1'b1;
      end else begin
        beat_data_s[i*IN_W +: IN_W] = asm_q[i*IN_W +: IN_W];
        beat_keep_s[i]              = keep_q[i];
      end
    end
    close_s = in_fire_s && (in_last || (state_q == FILL3));
  end

`ifdef WORD_PACKER_PARITY_EN
  assign beat_par_s = byte_parity(beat_data_s);
`endif

  // Assembly register next state: cleared when the beat closes
  always_comb begin
    asm_d  = asm_q;
    keep_d = keep_q;
    if (close_s) begin
      asm_d  = '0;
      keep_d = '0;
    end else if (in_fire_s) begin
      asm_d  = beat_data_s;
      keep_d = beat_keep_s;
    end else begin
      asm_d  = asm_q;
      keep_d = keep_q;
    end
  end

  // FIFO pointer/count next state and registered handshake outputs
  always_comb begin
    push_s   = close_s;
    pop_s    = (count_q != CNT_W'(0)) && out_ready;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != CNT_W'(0));
    // A push landing where the next read pointer points becomes the head directly
    fwd_s = push_s && (wr_ptr_q == rd_ptr_d);
  end

  // Next head contents for the output registers
  always_comb begin
    out_data_d = '0;
    out_keep_d = '0;
    out_last_d = 1'b0;
`ifdef WORD_PACKER_PARITY_EN
    out_par_d  = '0;
`endif
    if (!out_valid_d) begin
      out_data_d = '0;
      out_keep_d = '0;
      out_last_d = 1'b0;
    end else if (fwd_s) begin
      out_data_d = beat_data_s;
      out_keep_d = beat_keep_s;
      out_last_d = in_last;
`ifdef WORD_PACKER_PARITY_EN
      out_par_d  = beat_par_s;
`endif
    end else begin
      out_data_d = mem_data_q[rd_ptr_d];
      out_keep_d = mem_keep_q[rd_ptr_d];
      out_last_d = mem_last_q[rd_ptr_d];
`ifdef WORD_PACKER_PARITY_EN
      out_par_d  = mem_par_q[rd_ptr_d];
`endif
    end
  end

  // Assembly, FIFO control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      keep_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef WORD_PACKER_PARITY_EN
      out_par_q   <= '0;
`endif
    end else begin
      asm_q       <= asm_d;
      keep_q      <= keep_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
`ifdef WORD_PACKER_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  // FIFO storage, written at the closing word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_data_q[e] <= '0;
        mem_keep_q[e] <= '0;
        mem_last_q[e] <= 1'b0;
`ifdef WORD_PACKER_PARITY_EN
        mem_par_q[e]  <= '0;
`endif
      end
    end else if (push_s) begin
      mem_data_q[wr_ptr_q] <= beat_data_s;
      mem_keep_q[wr_ptr_q] <= beat_keep_s;
      mem_last_q[wr_ptr_q] <= in_last;
`ifdef WORD_PACKER_PARITY_EN
      mem_par_q[wr_ptr_q]  <= beat_par_s;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
`ifdef WORD_PACKER_PARITY_EN
  assign out_parity = out_par_q;
`endif

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Upstream feeder for the 128-bit reader stage.
- Accepts a stream of 32-bit words over a valid/ready handshake and packs four words into one 128-bit beat.
- Buffers completed beats in a 2-entry output FIFO.
- Presents beats to the downstream stage over a valid/ready handshake; the downstream data_valid/data_ready pair connects to out_valid/out_ready.

Parameters:
- IN_W, 32, input word width.
- WORDS, 4, words per beat; OUT_W = IN_W*WORDS = 128.
- DEPTH, 2, output FIFO entries (power of two).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  packer can accept a word.
- in_data  input  32  input word.
- in_last  input  1  final word of packet; closes the current beat early.
- out_valid  output  1  FIFO head beat valid.
- out_ready  input  1  downstream accepts the head beat.
- out_data  output  128  packed beat; word 0 in [31:0].
- out_keep  output  4  per-word valid mask of the head beat.
- out_last  output  1  head beat ends a packet.

Behaviour:
- Reset is asynchronous on rst high, released synchronously by design. All of the following are cleared:
  - word index, assembly register, FIFO pointers and count;
  - out_valid=0, out_data=0, out_keep=0, out_last=0;
  - in_ready=0 while rst is asserted, 1 in the first cycle after release.
  - Reset mid-packet discards the partial beat and all buffered beats; no partial beat emerges.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Word placement: word at index i is written to assembly bits [32*i+31:32*i] and keep bit i is set; the index then increments.
- Beat completion: a beat completes when the word at index 3 is accepted, or when any word with in_last=1 is accepted.
  - On completion, the assembled beat is pushed into the FIFO the same edge. Words not written are zero, and keep reflects the written words.
  - Example: in_last on index 2 gives keep=4'b0111 with bits [127:96]=0.
  - out_last is set to in_last of the closing word.
  - The index returns to 0 and the assembly register and keep are cleared.
- State: the word index 0..3 acts as the FSM.
  - FILL0 -> FILL1 -> FILL2 -> FILL3 -> FILL0.
  - in_last forces a return to FILL0 from any state.
- in_ready is registered and equals FIFO count != DEPTH, evaluated after the current edge's push/pop. It therefore deasserts the cycle after the FIFO fills and reasserts the cycle after a pop frees an entry. There is no combinational in->out path.
  - While in_ready=0, no words are accepted, including words that would not complete a beat. This is deliberate.
- Latency: the closing word accepted at edge N with the FIFO empty gives out_valid=1 after edge N.
- Output holding: out_data, out_keep and out_last come from the FIFO head and stay stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - the count is unchanged;
  - the pushed beat is ordered behind the popped one;
  - when the count is 1, the new head is the pushed beat the next cycle.
- Pop with the FIFO empty is ignored. A push with the FIFO full cannot occur, because in_ready is low.
- Throughput: sustained 1 word/cycle, i.e. 1 beat per 4 cycles, with out_ready held high.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro WORD_PACKER_PARITY_EN.
- When defined:
  - adds output port out_parity, width 16: even parity per byte of out_data, where bit k is the XOR of out_data[8k+7:8k];
  - parity is computed at push and stored in the FIFO alongside the beat;
  - reset value is 0.
- When undefined: the port and its storage are absent, and all other behaviour is identical.

Test Plan:
- Four words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=1 -> one beat, out_data=0x44444444_33333333_22222222_11111111, keep=4'b1111, out_last=0, out_valid one cycle after the 4th accept.
- Three words 0xA, 0xB, 0xC, the last with in_last=1 -> out_data=0x00000000_0000000C_0000000B_0000000A, keep=4'b0111, out_last=1; the next word lands at index 0.
- out_ready=0 while 12 words are offered -> two beats buffered, in_ready drops after the 2nd beat push, 8 words accepted; the 9th is held until one pop, then in_ready=1 the cycle after that pop.
- FIFO count 1, closing word accepted and head popped on the same edge -> count stays 1, out_data shows the new beat the next cycle, no beat lost or duplicated.
- rst pulsed asynchronously mid-beat after 2 words with 1 beat buffered -> out_valid=0 immediately; after release, 4 fresh words yield exactly one beat containing only the fresh data.
- WORD_PACKER_PARITY_EN defined, beat bytes all 0x01 -> out_parity=16'hFFFF; bytes all 0x03 -> 16'h0000.
